// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one byte-addressed memory between instruction fetch and load/store.
// Optional macro MEM_ARB_RR_EN selects round-robin arbitration; default is fixed data-port priority.
module mem_arbiter #(
    parameter int unsigned MEM_BYTES = 1376
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_in,
    output logic        mem_memwr,
    input  logic [31:0] mem_out
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    owner_t owner;
    logic   is_store;
    logic   err;
    logic   if_ok;
    logic   d_ok;
    logic   if_sel;
    logic   d_sel;

    // 33-bit sum keeps addresses near 2^32 from wrapping back into range.
    function automatic logic in_range(input logic [31:0] addr);
        logic [32:0] last_byte;
        last_byte = {1'b0, addr} + 33'd3;
        return last_byte < 33'(MEM_BYTES);
    endfunction

    assign if_ok = in_range(if_addr);
    assign d_ok  = in_range(d_addr);

`ifdef MEM_ARB_RR_EN
    logic last;  // winner of the last contended cycle: 0 = IF, 1 = D

    assign d_sel  = d_req & (~if_req | ~last);
    assign if_sel = if_req & ~d_sel;
`else
    assign d_sel  = d_req;
    assign if_sel = if_req & ~d_req;
`endif

    assign d_gnt     = rst_n & d_sel;
    assign if_gnt    = rst_n & if_sel;

    assign mem_raddr = d_sel ? d_addr : if_addr;
    assign mem_waddr = d_addr;
    assign mem_in    = d_wdata;
    assign mem_memwr = d_gnt & d_we & d_ok;

    // Response tag: captures who owns next cycle's mem_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= OWN_NONE;
            is_store <= 1'b0;
            err      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last     <= 1'b0;
`endif
        end else begin
            if (d_gnt) begin
                owner    <= OWN_D;
                is_store <= d_we;
                err      <= ~d_ok;
            end else if (if_gnt) begin
                owner    <= OWN_IF;
                is_store <= 1'b0;
                err      <= ~if_ok;
            end else begin
                owner    <= OWN_NONE;
                is_store <= 1'b0;
                err      <= 1'b0;
            end
`ifdef MEM_ARB_RR_EN
            if (if_req && d_req) begin
                last <= d_sel;
            end
`endif
        end
    end

    assign if_rvalid = (owner == OWN_IF);
    assign if_err    = if_rvalid & err;
    assign if_rdata  = (if_rvalid && !err) ? mem_out : 32'h0;

    assign d_rvalid  = (owner == OWN_D);
    assign d_err     = d_rvalid & err;
    assign d_rdata   = (d_rvalid && !err && !is_store) ? mem_out : 32'h0;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single byte-addressed instruction/data memory (`mem`) between the instruction-fetch port and the load/store data port. Sits between the core pipeline and `mem`. Issues at most one memory transaction per cycle, routes the one-cycle-latency registered read data back to the owning requester, and rejects out-of-range accesses without touching the memory.

## Interface

**Parameters**

- `MEM_BYTES`, default 1376: size of the attached memory in bytes. An access is in range iff `addr + 3 < MEM_BYTES`.

**Ports**

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request (read only)
- `if_addr`  in  32  fetch byte address
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  fetch response valid
- `if_rdata`  out  32  fetch data, little-endian word
- `if_err`  out  1  fetch out-of-range, qualified by `if_rvalid`
- `d_req`  in  1  data request
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  32  data byte address
- `d_wdata`  in  32  store data
- `d_gnt`  out  1  data request accepted this cycle
- `d_rvalid`  out  1  data response (load data or store ack)
- `d_rdata`  out  32  load data; 0 for stores and errors
- `d_err`  out  1  data out-of-range, qualified by `d_rvalid`
- `mem_raddr`  out  32  to `mem.raddr`
- `mem_waddr`  out  32  to `mem.waddr`
- `mem_in`  out  32  to `mem.in`
- `mem_memwr`  out  1  to `mem.memwr`
- `mem_out`  in  32  from `mem.out`, registered by `mem`

## Operation

- Grant logic is combinational from `*_req`. `*_gnt` is forced to 0 while `rst_n` = 0.
- **Fixed priority (default).** The data port wins when both requesters assert. A losing requester holds `req` and its address stable until it sees `gnt`.
- **Issue cycle.**
  - `mem_raddr` = the granted port's address.
  - `mem_waddr` = `d_addr` and `mem_in` = `d_wdata` at all times.
  - `mem_memwr` = `d_gnt & d_we & in_range`; it is 0 in every other case.
- **Response tag.** On each rising edge the block registers the tag `{owner ∈ NONE/IF/D, is_store, err}`. This is a two-phase state: IDLE when owner = NONE, RESP otherwise.
  - RESP of the selected owner: `*_rvalid` = 1.
  - `rdata` = `mem_out` for in-range loads and fetches; 0 for stores and errors.
- **Out-of-range request.** The request is still granted. No write is issued. The response arrives with `err` = 1 and `rdata` = 0.
- **Back-to-back grants.** Permitted every cycle. The tag is rewritten each cycle, so the response stream is fully pipelined.
- **Arithmetic.** The range check uses a 33-bit sum, so `addr` = 0xFFFFFFFE does not wrap into range.

## Timing

- Request granted in cycle T: `rvalid`, `rdata` and `err` are valid in cycle T+1, for exactly one cycle.
- A store granted in cycle T is written at the end of T. A load of the same address granted in T+1 returns the new data in T+2.
- Both requesters in the same cycle: exactly one `gnt`. There is never a double issue.
- **Reset values:** all `gnt`, `rvalid` and `err` = 0; `rdata` = 0; `mem_memwr` = 0; tag = NONE.
- **Reset asserted mid-transaction:** the pending response is discarded, and no `rvalid` follows the release of reset.
- In the first cycle after reset release, `rvalid` = 0 even if `mem_out` is non-zero.

## Configuration

- **`MEM_ARB_RR_EN`**
  - **Defined:** round-robin arbitration. A 1-bit `last` register records the winner of each contended cycle (reset value: IF). On contention the port that did not win last time is granted. Uncontended grants do not update `last`.
  - **Undefined:** fixed data-port priority, as in Operation. Fetch can be starved by continuous data requests.

## Test plan

- **Single fetch:** `if_req` with `if_addr` = 0x10, memory bytes 0x10..0x13 = 11 22 33 44 → `if_gnt` in T; `if_rvalid` = 1 with `if_rdata` = 0x44332211 in T+1; `if_err` = 0.
- **Store then load:** store 0xDEADBEEF to 0x20 in T, then load 0x20 in T+1 → `d_rvalid` with `d_rdata` = 0 in T+1; `d_rdata` = 0xDEADBEEF in T+2.
- **Contention:** `if_req` and `d_req` held for 4 cycles.
  - Without macro: grants D D D D, and fetch is never granted.
  - With `MEM_ARB_RR_EN`: grants D IF D IF after reset.
- **Out of range:** store to `d_addr` = 1373 (`MEM_BYTES` = 1376) → `mem_memwr` = 0; `d_err` = 1 next cycle; memory unchanged on readback.
- **Reset mid-flight:** load granted in T, `rst_n` low in T+1 → `d_rvalid` stays 0 through reset and after release.
- **Address wrap:** `if_addr` = 0xFFFFFFFE → `if_err` = 1 with `if_rdata` = 0.
